id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/fwd_unit.sv | 40 ++++
 rtl/id_ex_stage.sv | 154 +++++++++++++++
 tb/tb_id_ex_stage.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared widths, ALU function codes and forwarding-select encoding for the pipeline.
// The FORWARD_EN macro (used by fwd_unit and id_ex_stage) selects the bypass network.
package pipeline_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;

   localparam logic [5:0] ADD = 6'b000000;
   localparam logic [5:0] SUB = 6'b000001;
   localparam logic [5:0] AND = 6'b011000;
   localparam logic [5:0] OR  = 6'b011110;
   localparam logic [5:0] XOR = 6'b010110;
   localparam logic [5:0] NOR = 6'b010001;
   localparam logic [5:0] SLL = 6'b100000;
   localparam logic [5:0] SRL = 6'b100001;
   localparam logic [5:0] SRA = 6'b100011;
   localparam logic [5:0] EQ  = 6'b110011;
   localparam logic [5:0] NEQ = 6'b110001;
   localparam logic [5:0] LT  = 6'b110101;
   localparam logic [5:0] LEZ = 6'b111101;
   localparam logic [5:0] LTZ = 6'b111011;
   localparam logic [5:0] GTZ = 6'b111111;

   typedef enum logic [1:0] {FWD_REG, FWD_MEM, FWD_WB} fwd_sel_e;
endpackage

// File: rtl/fwd_unit.sv
// Operand bypass for one source register: MEM result beats WB result beats register data.
// With FORWARD_EN undefined the registered data always passes through.
module fwd_unit
   import pipeline_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] i_reg_addr,
   input  logic [DATA_W-1:0]     i_reg_data,
   input  logic [REG_ADDR_W-1:0] i_mem_rd_addr,
   input  logic                  i_mem_regwrite,
   input  logic [DATA_W-1:0]     i_mem_result,
   input  logic [REG_ADDR_W-1:0] i_wb_rd_addr,
   input  logic                  i_wb_regwrite,
   input  logic [DATA_W-1:0]     i_wb_result,
   output logic [DATA_W-1:0]     o_data
);
   fwd_sel_e w_sel;

`ifdef FORWARD_EN
   always_comb begin
      w_sel = FWD_REG;
      if (i_mem_regwrite && (i_mem_rd_addr == i_reg_addr) && (i_reg_addr != '0))
         w_sel = FWD_MEM;
      else if (i_wb_regwrite && (i_wb_rd_addr == i_reg_addr) && (i_reg_addr != '0))
         w_sel = FWD_WB;
   end
`else
   logic w_unused;
   assign w_sel    = FWD_REG;
   assign w_unused = ^{i_reg_addr, i_mem_rd_addr, i_mem_regwrite, i_mem_result,
                       i_wb_rd_addr, i_wb_regwrite, i_wb_result};
`endif

   always_comb begin
      case (w_sel)
         FWD_MEM: o_data = i_mem_result;
         FWD_WB:  o_data = i_wb_result;
         default: o_data = i_reg_data;
      endcase
   end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, bubble insertion and operand muxing.
// FORWARD_EN defined: MEM/WB bypass; undefined: any pending writer stalls the decode stage.
module id_ex_stage
   import pipeline_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs_addr,
   input  logic [REG_ADDR_W-1:0] id_rt_addr,
   input  logic [REG_ADDR_W-1:0] id_rd_addr,
   input  logic [DATA_W-1:0]     id_rs_data,
   input  logic [DATA_W-1:0]     id_rt_data,
   input  logic [DATA_W-1:0]     id_imm,
   input  logic [4:0]            id_shamt,
   input  logic                  id_alusrc_a,
   input  logic                  id_alusrc_b,
   input  logic [5:0]            id_alufun,
   input  logic                  id_sign,
   input  logic                  id_regwrite,
   input  logic                  id_memread,
   input  logic                  id_memwrite,
   input  logic                  flush,
   input  logic                  hold,
   input  logic [REG_ADDR_W-1:0] mem_rd_addr,
   input  logic                  mem_regwrite,
   input  logic [DATA_W-1:0]     mem_result,
   input  logic [REG_ADDR_W-1:0] wb_rd_addr,
   input  logic                  wb_regwrite,
   input  logic [DATA_W-1:0]     wb_result,
   output logic [DATA_W-1:0]     alu_a,
   output logic [DATA_W-1:0]     alu_b,
   output logic [5:0]            alu_fun,
   output logic                  alu_sign,
   output logic                  ex_valid,
   output logic                  ex_regwrite,
   output logic                  ex_memread,
   output logic                  ex_memwrite,
   output logic [REG_ADDR_W-1:0] ex_rd_addr,
   output logic [DATA_W-1:0]     ex_store_data,
   output logic                  id_stall,
   output logic [15:0]           bubble_cnt
);
   logic                  r_valid, r_regwrite, r_memread, r_memwrite;
   logic [REG_ADDR_W-1:0] r_rd_addr, r_rs_addr, r_rt_addr;
   logic [DATA_W-1:0]     r_rs_data, r_rt_data, r_imm;
   logic [4:0]            r_shamt;
   logic                  r_alusrc_a, r_alusrc_b, r_sign;
   logic [5:0]            r_alufun;
   logic [15:0]           r_bubble_cnt;

   logic                  w_ex_hit, w_load_use, w_hazard, w_lu_bubble;
   logic [DATA_W-1:0]     w_rs_fwd, w_rt_fwd;

   assign w_ex_hit   = (r_rd_addr != '0) && ((r_rd_addr == id_rs_addr) || (r_rd_addr == id_rt_addr));
   assign w_load_use = id_valid && r_valid && r_memread && w_ex_hit;

`ifdef FORWARD_EN
   assign w_hazard = !flush && w_load_use;
`else
   // Without bypassing, the register file only sees results once they reach WB.
   logic w_mem_hit, w_raw;
   assign w_mem_hit = (mem_rd_addr != '0) && ((mem_rd_addr == id_rs_addr) || (mem_rd_addr == id_rt_addr));
   assign w_raw     = id_valid && ((r_valid && r_regwrite && w_ex_hit) || (mem_regwrite && w_mem_hit));
   assign w_hazard  = !flush && (w_load_use || w_raw);
`endif

   assign w_lu_bubble = !flush && w_load_use;
   assign id_stall    = hold || w_hazard;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid      <= 1'b0;
         r_regwrite   <= 1'b0;
         r_memread    <= 1'b0;
         r_memwrite   <= 1'b0;
         r_rd_addr    <= '0;
         r_rs_addr    <= '0;
         r_rt_addr    <= '0;
         r_rs_data    <= '0;
         r_rt_data    <= '0;
         r_imm        <= '0;
         r_shamt      <= '0;
         r_alusrc_a   <= 1'b0;
         r_alusrc_b   <= 1'b0;
         r_sign       <= 1'b0;
         r_alufun     <= ADD;
         r_bubble_cnt <= '0;
      end else if (!hold) begin
         r_rs_addr  <= id_rs_addr;
         r_rt_addr  <= id_rt_addr;
         r_rs_data  <= id_rs_data;
         r_rt_data  <= id_rt_data;
         r_imm      <= id_imm;
         r_shamt    <= id_shamt;
         r_alusrc_a <= id_alusrc_a;
         r_alusrc_b <= id_alusrc_b;
         r_sign     <= id_sign;
         if (flush || w_hazard) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_rd_addr  <= '0;
            r_alufun   <= ADD;
         end else begin
            r_valid    <= id_valid;
            r_regwrite <= id_regwrite;
            r_memread  <= id_memread;
            r_memwrite <= id_memwrite;
            r_rd_addr  <= id_rd_addr;
            r_alufun   <= id_alufun;
         end
         if (w_lu_bubble && (r_bubble_cnt != 16'hFFFF))
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
      end
   end

   fwd_unit u_fwd_rs (
      .i_reg_addr     (r_rs_addr),
      .i_reg_data     (r_rs_data),
      .i_mem_rd_addr  (mem_rd_addr),
      .i_mem_regwrite (mem_regwrite),
      .i_mem_result   (mem_result),
      .i_wb_rd_addr   (wb_rd_addr),
      .i_wb_regwrite  (wb_regwrite),
      .i_wb_result    (wb_result),
      .o_data         (w_rs_fwd)
   );

   fwd_unit u_fwd_rt (
      .i_reg_addr     (r_rt_addr),
      .i_reg_data     (r_rt_data),
      .i_mem_rd_addr  (mem_rd_addr),
      .i_mem_regwrite (mem_regwrite),
      .i_mem_result   (mem_result),
      .i_wb_rd_addr   (wb_rd_addr),
      .i_wb_regwrite  (wb_regwrite),
      .i_wb_result    (wb_result),
      .o_data         (w_rt_fwd)
   );

   assign alu_a         = r_alusrc_a ? {27'b0, r_shamt} : w_rs_fwd;
   assign alu_b         = r_alusrc_b ? r_imm : w_rt_fwd;
   assign ex_store_data = w_rt_fwd;
   assign alu_fun       = r_alufun;
   assign alu_sign      = r_sign;
   assign ex_valid      = r_valid;
   assign ex_regwrite   = r_regwrite;
   assign ex_memread    = r_memread;
   assign ex_memwrite   = r_memwrite;
   assign ex_rd_addr    = r_rd_addr;
   assign bubble_cnt    = r_bubble_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: random and directed stimulus against a behavioural model.
// Build with or without FORWARD_EN; the model follows the same macro.
module tb_id_ex_stage;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
   logic [31:0] id_rs_data, id_rt_data, id_imm;
   logic [4:0]  id_shamt;
   logic        id_alusrc_a, id_alusrc_b;
   logic [5:0]  id_alufun;
   logic        id_sign, id_regwrite, id_memread, id_memwrite;
   logic        flush, hold;
   logic [4:0]  mem_rd_addr, wb_rd_addr;
   logic        mem_regwrite, wb_regwrite;
   logic [31:0] mem_result, wb_result;
   logic [31:0] alu_a, alu_b, ex_store_data;
   logic [5:0]  alu_fun;
   logic        alu_sign, ex_valid, ex_regwrite, ex_memread, ex_memwrite, id_stall;
   logic [4:0]  ex_rd_addr;
   logic [15:0] bubble_cnt;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
      .id_alusrc_a(id_alusrc_a), .id_alusrc_b(id_alusrc_b), .id_alufun(id_alufun), .id_sign(id_sign),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
      .flush(flush), .hold(hold),
      .mem_rd_addr(mem_rd_addr), .mem_regwrite(mem_regwrite), .mem_result(mem_result),
      .wb_rd_addr(wb_rd_addr), .wb_regwrite(wb_regwrite), .wb_result(wb_result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_sign(alu_sign),
      .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_rd_addr(ex_rd_addr), .ex_store_data(ex_store_data), .id_stall(id_stall), .bubble_cnt(bubble_cnt)
   );

   typedef struct packed {
      logic        valid, regwrite, memread, memwrite;
      logic [4:0]  rd, rs, rt;
      logic [31:0] rs_data, rt_data, imm;
      logic [4:0]  shamt;
      logic        asa, asb;
      logic [5:0]  fun;
      logic        sign;
   } ex_t;

   typedef struct packed {
      logic [31:0] alu_a, alu_b, store;
      logic [5:0]  fun;
      logic        sign, valid, regwrite, memread, memwrite;
      logic [4:0]  rd;
      logic        stall;
      logic [15:0] cnt;
   } exp_t;

   ex_t         m_ex;
   logic [15:0] m_cnt;
   exp_t        sb_q[$];
   event        ev_check;
   int          checks = 0;
   int          errors = 0;
   int          txn = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, want);
      end
   endtask

   function automatic logic [31:0] fwd_val(input logic [4:0] a, input logic [31:0] d);
`ifdef FORWARD_EN
      if (a != 5'd0 && mem_regwrite && mem_rd_addr == a) return mem_result;
      if (a != 5'd0 && wb_regwrite && wb_rd_addr == a) return wb_result;
`endif
      return d;
   endfunction

   function automatic logic hit(input logic [4:0] a);
      return (a != 5'd0) && (a == id_rs_addr || a == id_rt_addr);
   endfunction

   function automatic ex_t from_id();
      ex_t t;
      t.valid = id_valid; t.regwrite = id_regwrite; t.memread = id_memread; t.memwrite = id_memwrite;
      t.rd = id_rd_addr; t.rs = id_rs_addr; t.rt = id_rt_addr;
      t.rs_data = id_rs_data; t.rt_data = id_rt_data; t.imm = id_imm; t.shamt = id_shamt;
      t.asa = id_alusrc_a; t.asb = id_alusrc_b; t.fun = id_alufun; t.sign = id_sign;
      return t;
   endfunction

   // One clock: predict outputs for the current inputs, queue them, then advance the model.
   task automatic step();
      exp_t e;
      logic lu, hz;
      lu = id_valid && m_ex.valid && m_ex.memread && hit(m_ex.rd);
      hz = lu;
`ifndef FORWARD_EN
      hz = hz || (id_valid && ((m_ex.valid && m_ex.regwrite && hit(m_ex.rd)) || (mem_regwrite && hit(mem_rd_addr))));
`endif
      hz = hz && !flush;
      e.alu_a    = m_ex.asa ? {27'b0, m_ex.shamt} : fwd_val(m_ex.rs, m_ex.rs_data);
      e.alu_b    = m_ex.asb ? m_ex.imm : fwd_val(m_ex.rt, m_ex.rt_data);
      e.store    = fwd_val(m_ex.rt, m_ex.rt_data);
      e.fun      = m_ex.fun;
      e.sign     = m_ex.sign;
      e.valid    = m_ex.valid;
      e.regwrite = m_ex.regwrite;
      e.memread  = m_ex.memread;
      e.memwrite = m_ex.memwrite;
      e.rd       = m_ex.rd;
      e.stall    = hold || hz;
      e.cnt      = m_cnt;
      sb_q.push_back(e);
      #1;
      -> ev_check;
      @(posedge clk);
      if (!hold) begin
         if (flush || hz) m_ex = '0;
         else m_ex = from_id();
         if (!flush && lu && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      @(negedge clk);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(ev_check);
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            txn++;
            $display("txn %0d stall=%0b valid=%0b rd=%0d fun=%h alu_a=%h alu_b=%h st=%h cnt=%0d",
                     txn, id_stall, ex_valid, ex_rd_addr, alu_fun, alu_a, alu_b, ex_store_data, bubble_cnt);
            chk("id_stall", {31'b0, id_stall}, {31'b0, e.stall});
            chk("ex_valid", {31'b0, ex_valid}, {31'b0, e.valid});
            chk("ex_regwrite", {31'b0, ex_regwrite}, {31'b0, e.regwrite});
            chk("ex_memread", {31'b0, ex_memread}, {31'b0, e.memread});
            chk("ex_memwrite", {31'b0, ex_memwrite}, {31'b0, e.memwrite});
            chk("ex_rd_addr", {27'b0, ex_rd_addr}, {27'b0, e.rd});
            chk("alu_fun", {26'b0, alu_fun}, {26'b0, e.fun});
            chk("bubble_cnt", {16'b0, bubble_cnt}, {16'b0, e.cnt});
            if (e.valid) begin
               chk("alu_a", alu_a, e.alu_a);
               chk("alu_b", alu_b, e.alu_b);
               chk("ex_store_data", ex_store_data, e.store);
               chk("alu_sign", {31'b0, alu_sign}, {31'b0, e.sign});
            end
         end
      end
   end

   task automatic clear_inputs();
      id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0;
      id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0;
      id_alusrc_a = 0; id_alusrc_b = 0; id_alufun = 0; id_sign = 0;
      id_regwrite = 0; id_memread = 0; id_memwrite = 0;
      flush = 0; hold = 0;
      mem_rd_addr = 0; mem_regwrite = 0; mem_result = 0;
      wb_rd_addr = 0; wb_regwrite = 0; wb_result = 0;
   endtask

   task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic rw, input logic mr);
      id_valid = 1; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
      id_rs_data = rsd; id_rt_data = rtd; id_regwrite = rw; id_memread = mr;
      id_memwrite = 0; id_alusrc_a = 0; id_alusrc_b = 0; id_alufun = 6'b000001;
   endtask

   task automatic rand_inputs();
      id_valid = ($urandom_range(0, 9) != 0);
      id_rs_addr = 5'($urandom_range(0, 7)); id_rt_addr = 5'($urandom_range(0, 7));
      id_rd_addr = 5'($urandom_range(0, 7));
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_shamt = 5'($urandom); id_alusrc_a = ($urandom_range(0, 3) == 0);
      id_alusrc_b = 1'($urandom); id_alufun = 6'($urandom); id_sign = 1'($urandom);
      id_regwrite = 1'($urandom); id_memread = ($urandom_range(0, 2) == 0);
      id_memwrite = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0); hold = ($urandom_range(0, 9) == 0);
      mem_rd_addr = 5'($urandom_range(0, 7)); mem_regwrite = 1'($urandom); mem_result = $urandom;
      wb_rd_addr = 5'($urandom_range(0, 7)); wb_regwrite = 1'($urandom); wb_result = $urandom;
   endtask

   task automatic reset_model();
      m_ex = '0;
      m_cnt = 16'd0;
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      reset_model();
      #1;
      chk("reset_ex_valid", {31'b0, ex_valid}, 32'd0);
      chk("reset_alu_fun", {26'b0, alu_fun}, 32'd0);
      chk("reset_bubble_cnt", {16'b0, bubble_cnt}, 32'd0);
      chk("reset_alu_a", alu_a, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Load-use: lw r5 in EX, add using r5 in ID.
      set_id(5'd1, 5'd2, 5'd5, 32'h1, 32'h2, 1'b1, 1'b1);
      step();
      set_id(5'd5, 5'd6, 5'd7, 32'h50, 32'h60, 1'b1, 1'b0);
      #1 chk("loaduse_stall", {31'b0, id_stall}, 32'd1);
      step();
      chk("loaduse_cnt", {16'b0, bubble_cnt}, 32'd1);
      chk("loaduse_bubble", {31'b0, ex_valid}, 32'd0);
      step();
      step();

      // Flush beats the hazard; hold keeps EX and stalls ID.
      set_id(5'd1, 5'd2, 5'd5, 32'h1, 32'h2, 1'b1, 1'b1);
      step();
      set_id(5'd5, 5'd0, 5'd8, 32'h3, 32'h4, 1'b1, 1'b0);
      flush = 1;
      #1 chk("flush_no_stall", {31'b0, id_stall}, 32'd0);
      step();
      flush = 0;
      set_id(5'd1, 5'd2, 5'd5, 32'h1, 32'h2, 1'b1, 1'b1);
      step();
      set_id(5'd5, 5'd0, 5'd8, 32'h3, 32'h4, 1'b1, 1'b0);
      hold = 1; flush = 1;
      #1 chk("hold_flush_stall", {31'b0, id_stall}, 32'd1);
      step();
      chk("hold_keeps_rd", {27'b0, ex_rd_addr}, 32'd5);
      clear_inputs();
      step();

      // Forwarding priority on rs=3.
      set_id(5'd3, 5'd0, 5'd9, 32'h11, 32'h0, 1'b1, 1'b0);
      step();
      id_valid = 0; hold = 1;
      mem_rd_addr = 5'd3; mem_regwrite = 1; mem_result = 32'hAA;
      wb_rd_addr = 5'd3; wb_regwrite = 1; wb_result = 32'hBB;
`ifdef FORWARD_EN
      #1 chk("fwd_mem_prio", alu_a, 32'hAA);
`else
      #1 chk("fwd_off_mem", alu_a, 32'h11);
`endif
      step();
      mem_regwrite = 0;
`ifdef FORWARD_EN
      #1 chk("fwd_wb", alu_a, 32'hBB);
`else
      #1 chk("fwd_off_wb", alu_a, 32'h11);
`endif
      step();
      hold = 0;
      set_id(5'd0, 5'd0, 5'd9, 32'h11, 32'h0, 1'b1, 1'b0);
      step();
      id_valid = 0; hold = 1;
      mem_rd_addr = 5'd0; mem_regwrite = 1; wb_rd_addr = 5'd0; wb_regwrite = 1;
      #1 chk("fwd_r0_never", alu_a, 32'h11);
      step();
      clear_inputs();

      // Operand select: shamt/imm, store data from rt.
      set_id(5'd1, 5'd9, 5'd10, 32'h77, 32'h1234, 1'b1, 1'b0);
      id_alusrc_a = 1; id_shamt = 5'd7; id_alusrc_b = 1; id_imm = 32'hFFFFFFFC;
`ifdef FORWARD_EN
      id_rt_data = 32'h5555;
`endif
      step();
      clear_inputs();
      hold = 1;
`ifdef FORWARD_EN
      mem_rd_addr = 5'd9; mem_regwrite = 1; mem_result = 32'h1234;
`endif
      #1 chk("opsel_alu_a", alu_a, 32'h00000007);
      chk("opsel_alu_b", alu_b, 32'hFFFFFFFC);
      chk("opsel_store", ex_store_data, 32'h1234);
      step();
      clear_inputs();

`ifndef FORWARD_EN
      // Without bypassing an in-flight ALU writer must stall its consumer.
      set_id(5'd1, 5'd2, 5'd4, 32'h0, 32'h0, 1'b1, 1'b0);
      step();
      set_id(5'd4, 5'd0, 5'd6, 32'h0, 32'h0, 1'b1, 1'b0);
      #1 chk("nofwd_raw_stall", {31'b0, id_stall}, 32'd1);
      step();
      clear_inputs();
      step();
`endif

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         rand_inputs();
         step();
      end

      // Mid-stream reset, away from a clock edge.
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_ex_valid", {31'b0, ex_valid}, 32'd0);
      chk("midreset_bubble_cnt", {16'b0, bubble_cnt}, 32'd0);
      chk("midreset_alu_fun", {26'b0, alu_fun}, 32'd0);
      reset_model();
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Saturation: preset the counter near its top, then keep generating load-use bubbles.
      force dut.r_bubble_cnt = 16'hFFFA;
      #1 release dut.r_bubble_cnt;
      m_cnt = 16'hFFFA;
      set_id(5'd5, 5'd5, 5'd5, 32'h5, 32'h5, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) step();
      #1 chk("sat_bubble_cnt", {16'b0, bubble_cnt}, 32'h0000FFFF);
      @(negedge clk);

      #20;
      chk("scoreboard_drained", sb_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
